ram_bank: RTL and testbench

RAM_BANK -- requirements
Module: ram_bank

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_bank_ctrl.sv | 89 ++++++++
 rtl/ram_bank.sv | 85 ++++++++
 tb/tb_ram_bank.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_bank block.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // Smallest n with 2**n >= value; evaluated at elaboration for index widths.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_bank_ctrl.sv
// Request sequencing for ram_bank: IDLE/READ/CLEAR FSM, clear counter and
// the registered ACK, BUSY and read-valid outputs.
module ram_bank_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req,
  input  logic             wr_req,
  input  logic             clr_req,
  input  logic             hit,
  output logic             wr_en,
  output logic             rd_en,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_idx,
  output logic             ack,
  output logic             busy,
  output logic             rd_valid
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        // Clear outranks write, write outranks read.
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (hit && wr_req) begin
          wr_en = 1'b1;
        end else if (hit && rd_req) begin
          rd_en   = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        state_d = IDLE;
      end
      CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ack_d   = wr_en | rd_en;
    busy_d  = (state_d == CLEAR);
    valid_d = rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign clr_idx  = cnt_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/ram_bank.sv
// Flop-based memory bank mapped at BASE_ADDRESS on a shared bus, with
// registered reads, bulk clear and a tristated read-data port.
module ram_bank
  import ram_pkg::*;
#(
  parameter int unsigned             WORD_LENGTH  = 16,
  parameter int unsigned             ADDR_LENGTH  = 16,
  parameter int unsigned             DEPTH        = 16,
  parameter logic [ADDR_LENGTH-1:0]  BASE_ADDRESS = '0,
  parameter logic [WORD_LENGTH-1:0]  RESET_VALUE  = '0
) (
  input  logic                   CLK,
  input  logic                   bar_RST,
  input  logic                   RD_REQ,
  input  logic                   WR_REQ,
  input  logic                   CLR_REQ,
  input  logic [ADDR_LENGTH-1:0] ADDR_IN,
  input  logic [WORD_LENGTH-1:0] DATA_IN,
  output logic [WORD_LENGTH-1:0] DATA_OUT,
  output logic                   DATA_OUT_VALID,
  output logic                   ACK,
  output logic                   BUSY,
  output logic                   HIT
);

  localparam int unsigned IDX_W = log2_ceil(DEPTH);

  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       clr_idx;
  logic                   wr_en;
  logic                   rd_en;
  logic                   clr_en;
  logic [WORD_LENGTH-1:0] mem_q [DEPTH];
  logic [WORD_LENGTH-1:0] mem_d [DEPTH];
  logic [WORD_LENGTH-1:0] rd_data_q, rd_data_d;

  // BASE_ADDRESS is DEPTH-aligned, so the range check reduces to the upper bits.
  assign HIT = ((ADDR_IN >> IDX_W) == (BASE_ADDRESS >> IDX_W));
  assign idx = IDX_W'(ADDR_IN - BASE_ADDRESS);

  ram_bank_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ctrl (
    .clk      (CLK),
    .rst_n    (bar_RST),
    .rd_req   (RD_REQ),
    .wr_req   (WR_REQ),
    .clr_req  (CLR_REQ),
    .hit      (HIT),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx),
    .ack      (ACK),
    .busy     (BUSY),
    .rd_valid (DATA_OUT_VALID)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[idx] = DATA_IN;
    end
    if (clr_en) begin
      mem_d[clr_idx] = RESET_VALUE;
    end
    rd_data_d = rd_en ? mem_q[idx] : rd_data_q;
  end

  always_ff @(posedge CLK or negedge bar_RST) begin
    if (!bar_RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VALUE;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign DATA_OUT = DATA_OUT_VALID ? rd_data_q : 'z;

endmodule

// File: tb/tb_ram_bank.sv
// Bench for ram_bank: directed vector table, clear/reset sequences and
// randomized traffic checked against a transaction-level model.
module tb_ram_bank;

  localparam int unsigned W    = 16;
  localparam int unsigned A    = 16;
  localparam int unsigned D    = 16;
  localparam logic [15:0] BASE = 16'h0020;
  localparam logic [15:0] RV   = 16'hC3C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd, wr, clr;
  logic [15:0] addr, din;
  logic [15:0] dout;
  logic        valid, ack, busy, hit;

  logic        d_rd, d_wr, d_clr;
  logic [15:0] d_addr, d_din;
  logic [15:0] d_dout;
  logic        d_valid, d_ack, d_busy, d_hit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_bank #(
    .WORD_LENGTH  (W),
    .ADDR_LENGTH  (A),
    .DEPTH        (D),
    .BASE_ADDRESS (BASE),
    .RESET_VALUE  (RV)
  ) u_dut (
    .CLK            (clk),
    .bar_RST        (rst_n),
    .RD_REQ         (rd),
    .WR_REQ         (wr),
    .CLR_REQ        (clr),
    .ADDR_IN        (addr),
    .DATA_IN        (din),
    .DATA_OUT       (dout),
    .DATA_OUT_VALID (valid),
    .ACK            (ack),
    .BUSY           (busy),
    .HIT            (hit)
  );

  ram_bank u_def (
    .CLK            (clk),
    .bar_RST        (rst_n),
    .RD_REQ         (d_rd),
    .WR_REQ         (d_wr),
    .CLR_REQ        (d_clr),
    .ADDR_IN        (d_addr),
    .DATA_IN        (d_din),
    .DATA_OUT       (d_dout),
    .DATA_OUT_VALID (d_valid),
    .ACK            (d_ack),
    .BUSY           (d_busy),
    .HIT            (d_hit)
  );

  // ---------------- transaction-level reference model ----------------
  logic [15:0] m_mem [D];
  int          m_busy;      // remaining cycles of an ongoing clear
  bit          m_rd_pend;   // a read is being returned this cycle
  bit          m_ack, m_valid;
  logic [15:0] m_data;

  function automatic bit m_hit(input logic [15:0] a);
    return (32'(a) >= 32'(BASE)) && (32'(a) < 32'(BASE) + D);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = RV;
    m_busy = 0;
    m_rd_pend = 0;
    m_ack = 0;
    m_valid = 0;
    m_data = '0;
  endtask

  task automatic model_edge();
    m_ack = 0;
    m_valid = 0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (m_rd_pend) begin
      m_rd_pend = 0;
    end else if (clr) begin
      m_busy = D;
      for (int i = 0; i < D; i++) m_mem[i] = RV;
    end else if (m_hit(addr) && wr) begin
      m_mem[addr - BASE] = din;
      m_ack = 1;
    end else if (m_hit(addr) && rd) begin
      m_data = m_mem[addr - BASE];
      m_ack = 1;
      m_valid = 1;
      m_rd_pend = 1;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic hit_seen;

  task automatic cycle(input bit r, input bit w, input bit c,
                       input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; clr = c; addr = a; din = d;
    #1;
    hit_seen = hit;
    @(posedge clk);
    model_edge();
    #1;
    rd = 0; wr = 0; clr = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ack"}, ack, m_ack);
    check({tag, "_valid"}, valid, m_valid);
    check({tag, "_busy"}, busy, m_busy > 0);
    if (m_valid) check({tag, "_data"}, dout, m_data);
  endtask

  task automatic clear_and_count(input string tag);
    int busy_cnt;
    cycle(0, 0, 1, BASE, '0);
    check({tag, "_busy_start"}, busy, 1);
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < 40 && busy; k++) begin
      if (k == 7) begin
        cycle(0, 1, 0, BASE + 16'd3, 16'h7777);
        check({tag, "_midclear_ack"}, ack, 0);
      end else begin
        cycle(1, 0, 0, BASE + 16'd3, '0);
      end
      if (busy) busy_cnt++;
    end
    check({tag, "_busy_cycles"}, busy_cnt, D);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < D; i++) begin
      cycle(1, 0, 0, BASE + 16'(i), '0);
      check_model(tag);
      check({tag, "_rv"}, (valid && dout == RV), 1);
      cycle(0, 0, 0, BASE, '0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rd, wr, clr;
    logic [15:0] addr, din;
    bit          e_hit, e_ack, e_valid;
    logic [15:0] e_data;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit w, input logic [15:0] a,
                              input logic [15:0] d, input bit eh, input bit ea,
                              input bit ev, input logic [15:0] ed);
    vec_t v;
    v.rd = r; v.wr = w; v.clr = 0; v.addr = a; v.din = d;
    v.e_hit = eh; v.e_ack = ea; v.e_valid = ev; v.e_data = ed;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rd = 0; wr = 0; clr = 0; addr = '0; din = '0;
    d_rd = 0; d_wr = 0; d_clr = 0; d_addr = '0; d_din = '0;

    tbl.push_back(mk(0, 1, 16'h0023, 16'h1234, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0023, 16'h0000, 1, 1, 1, 16'h1234));
    tbl.push_back(mk(1, 0, 16'h0023, 16'h0000, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h0030, 16'hBEEF, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0030, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0020, 16'h0000, 1, 1, 1, RV));
    tbl.push_back(mk(0, 0, 16'h0020, 16'h0000, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h002F, 16'h5A5A, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h002F, 16'h0000, 1, 1, 1, 16'h5A5A));
    tbl.push_back(mk(0, 0, 16'h001F, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h001F, 16'h0000, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 16'h0025, 16'h00FF, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0025, 16'h0000, 1, 1, 1, 16'h00FF));
    tbl.push_back(mk(0, 0, 16'h0025, 16'h0000, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 16'h0024, 16'hABCD, 1, 1, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0024, 16'h0000, 1, 1, 1, 16'hABCD));
    tbl.push_back(mk(0, 0, 16'h0024, 16'h0000, 1, 0, 0, 16'h0000));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // Default-parameter instance: write then read at 0x0003
    @(posedge clk); #1;
    d_wr = 1; d_addr = 16'h0003; d_din = 16'h1234;
    #1 check("def_hit", d_hit, 1);
    @(posedge clk); #1;
    d_wr = 0;
    check("def_wr_ack", d_ack, 1);
    check("def_wr_valid", d_valid, 0);
    d_rd = 1;
    @(posedge clk); #1;
    d_rd = 0;
    check("def_wr_ack_pulse", d_ack, 1);
    check("def_rd_valid", d_valid, 1);
    check("def_rd_data", d_dout, 16'h1234);
    @(posedge clk); #1;
    check("def_rd_valid_drop", d_valid, 0);
    check("def_rd_ack_drop", d_ack, 0);
    @(negedge clk);

    // Directed table on the offset bank
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rd, tbl[i].wr, tbl[i].clr, tbl[i].addr, tbl[i].din);
      check($sformatf("vec%0d_hit", i), hit_seen, tbl[i].e_hit);
      check($sformatf("vec%0d_ack", i), ack, tbl[i].e_ack);
      check($sformatf("vec%0d_valid", i), valid, tbl[i].e_valid);
      check($sformatf("vec%0d_busy", i), busy, 0);
      if (tbl[i].e_valid) check($sformatf("vec%0d_data", i), dout, tbl[i].e_data);
    end

    // Fill with 0xAAAA, clear, confirm every word returns RESET_VALUE
    for (int i = 0; i < D; i++) begin
      cycle(0, 1, 0, BASE + 16'(i), 16'hAAAA);
      check("fill_ack", ack, 1);
    end
    clear_and_count("clr1");
    read_all("clr1_read");

    // Reset in the fifth clear cycle
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, BASE + 16'(i), 16'h1000 + 16'(i));
    cycle(0, 0, 1, BASE, '0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, BASE, '0);
    check("pre_abort_busy", busy, 1);
    #3;
    rst_n = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    check("abort_valid", valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    cycle(0, 0, 0, BASE, '0);
    check("post_rst_ack", ack, 0);
    check("post_rst_busy", busy, 0);
    read_all("abort_read");
    cycle(0, 1, 0, 16'h002A, 16'h9999);
    check("post_rst_wr_ack", ack, 1);
    cycle(1, 0, 0, 16'h002A, '0);
    check("post_rst_rd_valid", valid, 1);
    check("post_rst_rd_data", dout, 16'h9999);
    cycle(0, 0, 0, BASE, '0);

    // A second full clear must again last exactly DEPTH cycles
    clear_and_count("clr2");

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      bit          r, w, c;
      logic [15:0] a, d;
      r = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 59) == 0);
      a = 16'($urandom_range(16'h0018, 16'h0037));
      d = 16'($urandom);
      cycle(r, w, c, a, d);
      check("rand_hit", hit_seen, m_hit(a));
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
